// File: rtl/mdu_pkg.sv
// Shared op and state encodings for the multiply/divide unit.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // Ops that occupy the multiplier latency (plain and accumulating products).
    function automatic logic op_is_mul(input logic [3:0] op);
        logic r;
        case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
            default:                                                 r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic op_is_div(input logic [3:0] op);
        logic r;
        case (op)
            OP_DIV, OP_DIVU: r = 1'b1;
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic op_is_signed(input logic [3:0] op);
        logic r;
        case (op)
            OP_MULT, OP_DIV, OP_MADD, OP_MSUB: r = 1'b1;
            default:                           r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO.
// Define MDU_MADD_EN to enable the madd/maddu/msub/msubu accumulate ops.
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MDU_start,
    input  logic [3:0]       MDU_op,
    input  logic [WIDTH-1:0] MDU_src1,
    input  logic [WIDTH-1:0] MDU_src2,
    input  logic             E_req,
    output logic             MDU_busy,
    output logic [WIDTH-1:0] MDU_HI,
    output logic [WIDTH-1:0] MDU_LO
);

`ifdef MDU_MADD_EN
    localparam logic MADD_EN = 1'b1;
`else
    localparam logic MADD_EN = 1'b0;
`endif

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    mdu_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

    logic             op_legal_s, accept_s, done_s, sgn_s;
    logic [2*WIDTH-1:0] ext_a_s, ext_b_s, prod_s, acc_s;
    logic [WIDTH-1:0] mag_a_s, mag_b_s, dvsr_s, quo_u_s, rem_u_s, quo_s, rem_s;

    // Decode which incoming ops may be accepted in this build.
    always_comb begin
        op_legal_s = 1'b0;
        case (MDU_op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO: op_legal_s = 1'b1;
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU:                 op_legal_s = MADD_EN;
            default:                                              op_legal_s = 1'b0;
        endcase
    end

    assign accept_s = MDU_start & ~E_req & (state_q == ST_IDLE) & op_legal_s;

    // State register: everything clears asynchronously, discarding any in-flight op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 4'd0;
            a_q     <= ZERO;
            b_q     <= ZERO;
            hi_q    <= ZERO;
            lo_q    <= ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state: load latency on accept, count down, finish when the counter reaches 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && op_is_mul(MDU_op)) begin
                    state_d = ST_BUSY;
                    cnt_d   = 4'(MULT_CYCLES);
                end else if (accept_s && op_is_div(MDU_op)) begin
                    state_d = ST_BUSY;
                    cnt_d   = 4'(DIV_CYCLES);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Arithmetic from the latched operands. Signed divide works on magnitudes;
    // most-negative / -1 naturally yields quotient most-negative, remainder 0.
    always_comb begin
        sgn_s   = op_is_signed(op_q);
        ext_a_s = sgn_s ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        ext_b_s = sgn_s ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod_s  = ext_a_s * ext_b_s;
        acc_s   = {hi_q, lo_q};
        mag_a_s = (sgn_s && a_q[WIDTH-1]) ? (~a_q + ONE) : a_q;
        mag_b_s = (sgn_s && b_q[WIDTH-1]) ? (~b_q + ONE) : b_q;
        dvsr_s  = (b_q == ZERO) ? ONE : mag_b_s;
        quo_u_s = mag_a_s / dvsr_s;
        rem_u_s = mag_a_s % dvsr_s;
        quo_s   = (sgn_s && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? (~quo_u_s + ONE) : quo_u_s;
        rem_s   = (sgn_s && a_q[WIDTH-1]) ? (~rem_u_s + ONE) : rem_u_s;
    end

    // Operand latch on accept, HI/LO writes for moves and completions.
    always_comb begin
        op_d = op_q;
        a_d  = a_q;
        b_d  = b_q;
        hi_d = hi_q;
        lo_d = lo_q;
        if (accept_s) begin
            op_d = MDU_op;
            a_d  = MDU_src1;
            b_d  = MDU_src2;
            case (MDU_op)
                OP_MTHI: hi_d = MDU_src1;
                OP_MTLO: lo_d = MDU_src1;
                default: hi_d = hi_q;
            endcase
        end else if (done_s) begin
            case (op_q)
                OP_MULT, OP_MULTU: {hi_d, lo_d} = prod_s;
                OP_MADD, OP_MADDU: {hi_d, lo_d} = acc_s + prod_s;
                OP_MSUB, OP_MSUBU: {hi_d, lo_d} = acc_s - prod_s;
                OP_DIV, OP_DIVU: begin
                    if (b_q != ZERO) begin
                        hi_d = rem_s;
                        lo_d = quo_s;
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                end
                default: hi_d = hi_q;
            endcase
        end else begin
            op_d = op_q;
        end
    end

    assign MDU_busy = (state_q == ST_BUSY);
    assign MDU_HI   = hi_q;
    assign MDU_LO   = lo_q;

endmodule
